// File: rtl/dc3_code_rx.sv
`default_nettype none
// ============================================================================
//  Module      : dc3_code_rx
//  Description : Receive side of the 3-bit DC3 code link. Synchronises the
//                asynchronous code, waits until it has been stable for
//                STABLE_CYC clocks, then decodes it back to a 2-bit index.
//                Legal codes update x with a one-cycle valid strobe. Illegal
//                codes raise err and bump a saturating counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module dc3_code_rx #(
  parameter int STABLE_CYC = 4,   // 1..255
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       code,
  output logic [1:0]       x,
  output logic             valid,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             settling
);

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCEPT = 2'd2
  } state_t;

  // Run count at which the settle window is complete.
  localparam logic [7:0]       c_run_last = 8'(STABLE_CYC - 1);
  localparam logic [ERR_W-1:0] c_cnt_one  = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_s1;
  logic [2:0] r_s2;
  logic [2:0] r_s_prev;
  logic [7:0] r_run;
  logic [7:0] w_run_nxt;
  logic       w_chg;
  logic       w_accept;
  logic       w_legal;
  logic [1:0] w_idx;

  // Two-flop synchroniser plus a one-cycle-delayed copy for change detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1     <= 3'b000;
      r_s2     <= 3'b000;
      r_s_prev <= 3'b000;
    end else begin
      r_s1     <= code;
      r_s2     <= r_s1;
      r_s_prev <= r_s2;
    end
  end

  assign w_chg = (r_s2 != r_s_prev);

  // Decode the synchronised code; anything outside the four legal patterns
  // is flagged illegal.
  always_comb begin
    w_legal = 1'b1;
    w_idx   = 2'b00;
    case (r_s2)
      3'b110:  w_idx = 2'b00;
      3'b101:  w_idx = 2'b01;
      3'b011:  w_idx = 2'b10;
      3'b111:  w_idx = 2'b11;
      default: w_legal = 1'b0;
    endcase
  end

  // State and run-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_HOLD;
      r_run   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
    end
  end

  // Next-state logic. The acceptance is registered on the edge that enters
  // ACCEPT, so the valid strobe coincides with the ACCEPT cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_accept    = 1'b0;
    case (r_state)
      ST_HOLD: begin
        if (w_chg) begin
          w_state_nxt = ST_SETTLE;
          w_run_nxt   = 8'd0;
        end
      end
      ST_SETTLE: begin
        if (w_chg) begin
          w_run_nxt = 8'd0;
        end else if (r_run == c_run_last) begin
          w_state_nxt = ST_ACCEPT;
          w_accept    = 1'b1;
        end else begin
          w_run_nxt = r_run + 8'd1;
        end
      end
      ST_ACCEPT: begin
        if (w_chg) begin
          w_state_nxt = ST_SETTLE;
          w_run_nxt   = 8'd0;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_HOLD;
        w_run_nxt   = 8'd0;
      end
    endcase
  end

  // Output registers: update index/strobe or error flag and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x       <= 2'b00;
      valid   <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      valid <= 1'b0;
      if (w_accept) begin
        if (w_legal) begin
          x     <= w_idx;
          valid <= 1'b1;
          err   <= 1'b0;
        end else begin
          err <= 1'b1;
          if (err_cnt != {ERR_W{1'b1}}) begin
            err_cnt <= err_cnt + c_cnt_one;
          end
        end
      end
    end
  end

  assign settling = (r_state == ST_SETTLE);

endmodule
`default_nettype wire

// File: tb/tb_dc3_code_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dc3_code_rx
//  Description : Scoreboard bench for dc3_code_rx. Stimulus pushes expected
//                acceptances; monitors pop them when settling falls.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dc3_code_rx;

  typedef struct packed {
    logic [1:0] x;
    logic       v;
    logic       e;
    logic [7:0] c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] code1;
  logic [2:0] code2;
  logic [1:0] x1, x2;
  logic       valid1, valid2, err1, err2, settling1, settling2;
  logic [7:0] err_cnt1;
  logic [1:0] err_cnt2;

  int tests = 0;
  int fails = 0;

  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  dc3_code_rx #(.STABLE_CYC(4), .ERR_W(8)) u_dut (
    .clk(clk), .rst(rst), .code(code1), .x(x1), .valid(valid1),
    .err(err1), .err_cnt(err_cnt1), .settling(settling1)
  );

  dc3_code_rx #(.STABLE_CYC(4), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .code(code2), .x(x2), .valid(valid2),
    .err(err2), .err_cnt(err_cnt2), .settling(settling2)
  );

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] xx, input logic v,
                              input logic e, input logic [7:0] c);
    exp_t t;
    t.x = xx; t.v = v; t.e = e; t.c = c;
    return t;
  endfunction

  task automatic drive1(input logic [2:0] c, input int n);
    @(negedge clk);
    code1 = c;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive2(input logic [2:0] c, input int n);
    @(negedge clk);
    code2 = c;
    repeat (n) @(negedge clk);
  endtask

  // Monitor for the main instance: an acceptance is the cycle after settling
  // drops (SETTLE only leaves to ACCEPT outside reset).
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (prev && !settling1) begin
          tests++;
          if (q1.size() == 0) begin
            fails++;
            $display("FAIL acc1_unexpected: got x=%0d valid=%0d err=%0d cnt=%0d, want no acceptance",
                     x1, valid1, err1, err_cnt1);
          end else begin
            e = q1.pop_front();
            if (x1 !== e.x || valid1 !== e.v || err1 !== e.e || err_cnt1 !== e.c) begin
              fails++;
              $display("FAIL acc1: got x=%0d valid=%0d err=%0d cnt=%0d, want x=%0d valid=%0d err=%0d cnt=%0d",
                       x1, valid1, err1, err_cnt1, e.x, e.v, e.e, e.c);
            end
          end
        end else if (valid1 !== 1'b0) begin
          tests++;
          fails++;
          $display("FAIL valid1_spurious: got valid=%0d want 0", valid1);
        end
        prev = settling1;
      end
    end
  end

  // Monitor for the narrow-counter instance.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (prev && !settling2) begin
          tests++;
          if (q2.size() == 0) begin
            fails++;
            $display("FAIL acc2_unexpected: got x=%0d valid=%0d err=%0d cnt=%0d, want no acceptance",
                     x2, valid2, err2, err_cnt2);
          end else begin
            e = q2.pop_front();
            if (x2 !== e.x || valid2 !== e.v || err2 !== e.e || {6'b0, err_cnt2} !== e.c) begin
              fails++;
              $display("FAIL acc2: got x=%0d valid=%0d err=%0d cnt=%0d, want x=%0d valid=%0d err=%0d cnt=%0d",
                       x2, valid2, err2, err_cnt2, e.x, e.v, e.e, e.c);
            end
          end
        end else if (valid2 !== 1'b0) begin
          tests++;
          fails++;
          $display("FAIL valid2_spurious: got valid=%0d want 0", valid2);
        end
        prev = settling2;
      end
    end
  end

  // Stimulus
  initial begin
    int k;
    int found;
    int all_high;
    logic [2:0] alt [5];
    logic [7:0] alt_cnt [5];

    rst   = 1'b1;
    code1 = 3'b110;
    code2 = 3'b000;
    #1;
    chk("reset_x", int'(x1), 0);
    chk("reset_valid", int'(valid1), 0);
    chk("reset_err_cnt", int'(err_cnt1), 0);
    chk("reset_settling", int'(settling1), 0);

    // 1) Latency after reset with 110 applied.
    q1.push_back(mk(2'b00, 1'b1, 1'b0, 8'd0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);  // E0
    found = 0;
    for (k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (valid1) begin
        found = k;
        break;
      end
    end
    chk("latency_edges", found, 6);
    repeat (20) @(negedge clk);

    // 2) Legal sequence.
    q1.push_back(mk(2'b01, 1'b1, 1'b0, 8'd0));
    drive1(3'b101, 20);
    q1.push_back(mk(2'b10, 1'b1, 1'b0, 8'd0));
    drive1(3'b011, 20);
    q1.push_back(mk(2'b11, 1'b1, 1'b0, 8'd0));
    drive1(3'b111, 20);
    chk("seq_err_cnt", int'(err_cnt1), 0);

    // 3) Glitch from accepted 110.
    q1.push_back(mk(2'b00, 1'b1, 1'b0, 8'd0));
    drive1(3'b110, 20);
    q1.push_back(mk(2'b00, 1'b1, 1'b0, 8'd0));
    @(negedge clk);
    code1 = 3'b101;
    repeat (3) @(negedge clk);
    code1 = 3'b110;
    all_high = settling1 ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!settling1) all_high = 0;
    end
    chk("glitch_settling", all_high, 1);
    repeat (20) @(negedge clk);

    // 4) Illegal code after x=10, then recovery.
    q1.push_back(mk(2'b10, 1'b1, 1'b0, 8'd0));
    drive1(3'b011, 20);
    q1.push_back(mk(2'b10, 1'b0, 1'b1, 8'd1));
    drive1(3'b100, 10);
    chk("illegal_err", int'(err1), 1);
    chk("illegal_cnt", int'(err_cnt1), 1);
    chk("illegal_x", int'(x1), 2);
    q1.push_back(mk(2'b11, 1'b1, 1'b0, 8'd1));
    drive1(3'b111, 20);

    // 5) Reset two cycles into SETTLE.
    @(negedge clk);
    code1 = 3'b011;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (settling1) begin
        found = 1;
        break;
      end
    end
    chk("rst_test_settle_seen", found, 1);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_x", int'(x1), 0);
    chk("midrst_valid", int'(valid1), 0);
    chk("midrst_err", int'(err1), 0);
    chk("midrst_cnt", int'(err_cnt1), 0);
    chk("midrst_settling", int'(settling1), 0);
    repeat (3) @(negedge clk);
    q1.push_back(mk(2'b10, 1'b1, 1'b0, 8'd0));
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 6) Narrow counter saturation; code2 has sat at 000 since reset.
    chk("idle000_err", int'(err2), 0);
    chk("idle000_cnt", int'(err_cnt2), 0);
    alt[0] = 3'b010; alt[1] = 3'b000; alt[2] = 3'b010; alt[3] = 3'b000; alt[4] = 3'b010;
    alt_cnt[0] = 8'd1; alt_cnt[1] = 8'd2; alt_cnt[2] = 8'd3; alt_cnt[3] = 8'd3; alt_cnt[4] = 8'd3;
    for (int i = 0; i < 5; i++) begin
      q2.push_back(mk(2'b00, 1'b0, 1'b1, alt_cnt[i]));
      drive2(alt[i], 10);
    end
    chk("sat_err", int'(err2), 1);

    repeat (5) @(negedge clk);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time limit.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
